// File: rtl/pipe_stage_reg_if.sv
// Handshake/payload bundle for one pipeline stage register.
// Upstream side : in_valid, in_ready, in_data, in_ctrl, stall, flush
// Downstream    : out_valid, out_ready, out_data, out_ctrl
// Perf counters : bubble_cnt, stall_cnt
// The slave modport is the stage register's view; master is the environment's view.
interface pipe_stage_reg_if #(
    parameter int unsigned DATA_W = 96,
    parameter int unsigned CTRL_W = 16,
    parameter int unsigned CNT_W  = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              stall;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;
    logic [CNT_W-1:0]  bubble_cnt;
    logic [CNT_W-1:0]  stall_cnt;

    modport master (
        output in_valid, in_data, in_ctrl, stall, flush, out_ready,
        input  in_ready, out_valid, out_data, out_ctrl, bubble_cnt, stall_cnt
    );

    modport slave (
        input  in_valid, in_data, in_ctrl, stall, flush, out_ready,
        output in_ready, out_valid, out_data, out_ctrl, bubble_cnt, stall_cnt
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready handshake, stall, flush,
// optional 2-entry skid buffer and saturating stall/bubble counters.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous active-high reset
//   bus   - pipe_stage_reg_if.slave: upstream handshake + payload, stall,
//           flush, downstream handshake + payload, perf counters
// An invalid entry always holds zero data/ctrl, so an empty or flushed
// slot presents a NOP downstream.
module pipe_stage_reg #(
    parameter int unsigned DATA_W = 96,
    parameter int unsigned CTRL_W = 16,
    parameter int unsigned SKID   = 1,
    parameter int unsigned CNT_W  = 16
) (
    input  logic            clk,
    input  logic            reset,
    pipe_stage_reg_if.slave bus
);

    localparam bit USE_SKID = (SKID != 0);

    // Occupancy: main entry valid in ONE/FULL, skid entry valid only in FULL
    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    logic [1:0]        r_state;
    logic [DATA_W-1:0] r_main_data;
    logic [CTRL_W-1:0] r_main_ctrl;
    logic [DATA_W-1:0] r_skid_data;
    logic [CTRL_W-1:0] r_skid_ctrl;
    logic [CNT_W-1:0]  r_bubble_cnt;
    logic [CNT_W-1:0]  r_stall_cnt;

    logic [1:0]        w_state_nxt;
    logic [DATA_W-1:0] w_main_data_nxt;
    logic [CTRL_W-1:0] w_main_ctrl_nxt;
    logic [DATA_W-1:0] w_skid_data_nxt;
    logic [CTRL_W-1:0] w_skid_ctrl_nxt;
    logic              w_main_valid;
    logic              w_skid_valid;
    logic              w_in_ready;
    logic              w_in_xfer;
    logic              w_out_xfer;

    assign w_main_valid = (r_state == ST_ONE) || (r_state == ST_FULL);
    assign w_skid_valid = (r_state == ST_FULL);

    // With the skid buffer only stall/flush reach in_ready combinationally;
    // without it, out_ready feeds straight through.
    assign w_in_ready = ~reset & ~bus.stall & ~bus.flush &
                        (USE_SKID ? ~w_skid_valid : (~w_main_valid | bus.out_ready));
    assign w_in_xfer  = bus.in_valid & w_in_ready;
    assign w_out_xfer = w_main_valid & bus.out_ready;

    // Next occupancy and entry contents; flush wins over every transfer
    always_comb begin
        w_state_nxt     = r_state;
        w_main_data_nxt = r_main_data;
        w_main_ctrl_nxt = r_main_ctrl;
        w_skid_data_nxt = r_skid_data;
        w_skid_ctrl_nxt = r_skid_ctrl;
        if (bus.flush) begin
            w_state_nxt     = ST_EMPTY;
            w_main_data_nxt = '0;
            w_main_ctrl_nxt = '0;
            w_skid_data_nxt = '0;
            w_skid_ctrl_nxt = '0;
        end else begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_in_xfer) begin
                        w_state_nxt     = ST_ONE;
                        w_main_data_nxt = bus.in_data;
                        w_main_ctrl_nxt = bus.in_ctrl;
                    end
                end
                ST_ONE: begin
                    if (w_in_xfer && w_out_xfer) begin
                        w_main_data_nxt = bus.in_data;
                        w_main_ctrl_nxt = bus.in_ctrl;
                    end else if (w_in_xfer) begin
                        // Only reachable with the skid buffer enabled
                        w_state_nxt     = ST_FULL;
                        w_skid_data_nxt = bus.in_data;
                        w_skid_ctrl_nxt = bus.in_ctrl;
                    end else if (w_out_xfer) begin
                        w_state_nxt     = ST_EMPTY;
                        w_main_data_nxt = '0;
                        w_main_ctrl_nxt = '0;
                    end
                end
                ST_FULL: begin
                    if (w_out_xfer) begin
                        w_state_nxt     = ST_ONE;
                        w_main_data_nxt = r_skid_data;
                        w_main_ctrl_nxt = r_skid_ctrl;
                        w_skid_data_nxt = '0;
                        w_skid_ctrl_nxt = '0;
                    end
                end
                default: begin
                    w_state_nxt     = ST_EMPTY;
                    w_main_data_nxt = '0;
                    w_main_ctrl_nxt = '0;
                    w_skid_data_nxt = '0;
                    w_skid_ctrl_nxt = '0;
                end
            endcase
        end
    end

    // Entry and occupancy registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_EMPTY;
            r_main_data <= '0;
            r_main_ctrl <= '0;
            r_skid_data <= '0;
            r_skid_ctrl <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_main_data <= w_main_data_nxt;
            r_main_ctrl <= w_main_ctrl_nxt;
            r_skid_data <= w_skid_data_nxt;
            r_skid_ctrl <= w_skid_ctrl_nxt;
        end
    end

    // Saturating performance counters; flush does not touch them
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_bubble_cnt <= '0;
            r_stall_cnt  <= '0;
        end else begin
            if (!w_main_valid && (r_bubble_cnt != {CNT_W{1'b1}})) begin
                r_bubble_cnt <= r_bubble_cnt + CNT_W'(1);
            end
            if (bus.stall && bus.in_valid && (r_stall_cnt != {CNT_W{1'b1}})) begin
                r_stall_cnt <= r_stall_cnt + CNT_W'(1);
            end
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = w_main_valid;
    assign bus.out_data   = r_main_data;
    assign bus.out_ctrl   = r_main_ctrl;
    assign bus.bubble_cnt = r_bubble_cnt;
    assign bus.stall_cnt  = r_stall_cnt;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: u_dut0 has no skid buffer (16-bit counters),
// u_dut1 has the skid buffer with 4-bit counters. A negedge monitor per DUT
// queues every accepted input and checks each output transfer against it.
module tb_pipe_stage_reg;
    localparam int unsigned DW = 96;
    localparam int unsigned CW = 16;

    logic clk = 1'b0;
    logic reset;
    int   n_vec = 0;
    int   n_err = 0;
    logic [DW+CW-1:0] q0[$];
    logic [DW+CW-1:0] q1[$];

    pipe_stage_reg_if #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(16)) if0 ();
    pipe_stage_reg_if #(.DATA_W(DW), .CTRL_W(CW), .CNT_W(4))  if1 ();

    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(0), .CNT_W(16)) u_dut0 (
        .clk(clk), .reset(reset), .bus(if0));
    pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1), .CNT_W(4)) u_dut1 (
        .clk(clk), .reset(reset), .bus(if1));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drv0(input logic v, input logic [CW-1:0] c);
        if0.in_valid = v;
        if0.in_ctrl  = v ? c : '0;
        if0.in_data  = v ? {$urandom, $urandom, $urandom} : '0;
    endtask

    task automatic drv1(input logic v, input logic [CW-1:0] c);
        if1.in_valid = v;
        if1.in_ctrl  = v ? c : '0;
        if1.in_data  = v ? {$urandom, $urandom, $urandom} : '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drv0(1'b0, '0);
        drv1(1'b0, '0);
        if0.stall = 1'b0; if0.flush = 1'b0; if0.out_ready = 1'b1;
        if1.stall = 1'b0; if1.flush = 1'b0; if1.out_ready = 1'b1;
        tick();
        tick();
        q0.delete();
        q1.delete();
        reset = 1'b0;
    endtask

    // Scoreboard monitor, no-skid DUT
    always @(negedge clk) begin : mon0
        logic [DW+CW-1:0] e;
        if (!reset) begin
            if (!if0.out_valid) begin
                chk("d0_nop_ctrl", 128'(if0.out_ctrl), 128'(0));
                chk("d0_nop_data", 128'(if0.out_data), 128'(0));
            end
            if (if0.flush) begin
                q0.delete();
            end else begin
                if (if0.out_valid && if0.out_ready) begin
                    if (q0.size() == 0) begin
                        chk("d0_spurious", 128'(if0.out_valid), 128'(0));
                    end else begin
                        e = q0.pop_front();
                        chk("d0_ctrl", 128'(if0.out_ctrl), 128'(e[CW-1:0]));
                        chk("d0_data", 128'(if0.out_data), 128'(e[DW+CW-1:CW]));
                    end
                end
                if (if0.in_valid && if0.in_ready) q0.push_back({if0.in_data, if0.in_ctrl});
            end
        end
    end

    // Scoreboard monitor, skid DUT
    always @(negedge clk) begin : mon1
        logic [DW+CW-1:0] e;
        if (!reset) begin
            if (!if1.out_valid) begin
                chk("d1_nop_ctrl", 128'(if1.out_ctrl), 128'(0));
                chk("d1_nop_data", 128'(if1.out_data), 128'(0));
            end
            if (if1.flush) begin
                q1.delete();
            end else begin
                if (if1.out_valid && if1.out_ready) begin
                    if (q1.size() == 0) begin
                        chk("d1_spurious", 128'(if1.out_valid), 128'(0));
                    end else begin
                        e = q1.pop_front();
                        chk("d1_ctrl", 128'(if1.out_ctrl), 128'(e[CW-1:0]));
                        chk("d1_data", 128'(if1.out_data), 128'(e[DW+CW-1:CW]));
                    end
                end
                if (if1.in_valid && if1.in_ready) q1.push_back({if1.in_data, if1.in_ctrl});
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        drv0(1'b0, '0);
        drv1(1'b0, '0);
        if0.stall = 1'b0; if0.flush = 1'b0; if0.out_ready = 1'b1;
        if1.stall = 1'b0; if1.flush = 1'b0; if1.out_ready = 1'b1;
        #2;
        chk("rst_rdy0", 128'(if0.in_ready), 128'(0));
        chk("rst_rdy1", 128'(if1.in_ready), 128'(0));
        chk("rst_ov0", 128'(if0.out_valid), 128'(0));
        chk("rst_ov1", 128'(if1.out_valid), 128'(0));
        chk("rst_bcnt0", 128'(if0.bubble_cnt), 128'(0));
        chk("rst_scnt1", 128'(if1.stall_cnt), 128'(0));
        do_reset();

        // Back-to-back stream through the no-skid stage
        for (int i = 1; i <= 8; i++) begin
            drv0(1'b1, CW'(i));
            tick();
            chk("st_valid", 128'(if0.out_valid), 128'(1));
            chk("st_ctrl", 128'(if0.out_ctrl), 128'(i));
        end
        drv0(1'b0, '0);
        if0.out_ready = 1'b0;
        #1;
        chk("st_rdy_bp", 128'(if0.in_ready), 128'(0));
        if0.out_ready = 1'b1;
        #1;
        chk("st_rdy_comb", 128'(if0.in_ready), 128'(1));
        tick();
        chk("st_drained", 128'(if0.out_valid), 128'(0));

        // Load-use bubble: stall two cycles while one entry drains
        do_reset();
        drv0(1'b1, 16'h0030);
        tick();
        chk("lu_held", 128'(if0.out_valid), 128'(1));
        if0.stall = 1'b1;
        drv0(1'b1, 16'h0031);
        tick();
        chk("lu_drain", 128'(if0.out_valid), 128'(0));
        tick();
        chk("lu_bubble", 128'(if0.out_valid), 128'(0));
        chk("lu_bcnt", 128'(if0.bubble_cnt), 128'(2));
        chk("lu_scnt", 128'(if0.stall_cnt), 128'(2));
        if0.stall = 1'b0;
        tick();
        chk("lu_issue", 128'(if0.out_ctrl), 128'(16'h0031));
        chk("lu_bcnt2", 128'(if0.bubble_cnt), 128'(3));
        chk("lu_scnt2", 128'(if0.stall_cnt), 128'(2));
        drv0(1'b0, '0);
        tick();

        // Asynchronous reset while the skid stage is FULL
        do_reset();
        if1.out_ready = 1'b0;
        drv1(1'b1, 16'h0011);
        tick();
        drv1(1'b1, 16'h0022);
        tick();
        chk("mr_full_rdy", 128'(if1.in_ready), 128'(0));
        chk("mr_head", 128'(if1.out_ctrl), 128'(16'h0011));
        chk("mr_bcnt_pre", 128'(if1.bubble_cnt), 128'(1));
        drv1(1'b0, '0);
        #2;
        reset = 1'b1;
        #1;
        chk("mr_ov", 128'(if1.out_valid), 128'(0));
        chk("mr_ctrl", 128'(if1.out_ctrl), 128'(0));
        chk("mr_data", 128'(if1.out_data), 128'(0));
        chk("mr_rdy", 128'(if1.in_ready), 128'(0));
        chk("mr_bcnt", 128'(if1.bubble_cnt), 128'(0));
        chk("mr_scnt", 128'(if1.stall_cnt), 128'(0));
        do_reset();

        // Backpressure into the skid buffer, then drain in FIFO order
        if1.out_ready = 1'b0;
        drv1(1'b1, 16'h00A1);
        #1;
        chk("bp_rdyA", 128'(if1.in_ready), 128'(1));
        tick();
        drv1(1'b1, 16'h00B2);
        #1;
        chk("bp_rdyB", 128'(if1.in_ready), 128'(1));
        tick();
        drv1(1'b1, 16'h00C3);
        #1;
        chk("bp_rdyC", 128'(if1.in_ready), 128'(0));
        tick();
        chk("bp_hold", 128'(if1.in_ready), 128'(0));
        chk("bp_head", 128'(if1.out_ctrl), 128'(16'h00A1));
        if1.out_ready = 1'b1;
        #1;
        chk("bp_nocomb", 128'(if1.in_ready), 128'(0));
        tick();
        chk("bp_rdyC2", 128'(if1.in_ready), 128'(1));
        chk("bp_headB", 128'(if1.out_ctrl), 128'(16'h00B2));
        tick();
        chk("bp_headC", 128'(if1.out_ctrl), 128'(16'h00C3));
        drv1(1'b0, '0);
        tick();
        chk("bp_empty", 128'(if1.out_valid), 128'(0));

        // Stall and flush in the same cycle
        do_reset();
        if1.out_ready = 1'b0;
        drv1(1'b1, 16'h0055);
        tick();
        chk("sf_one", 128'(if1.out_ctrl), 128'(16'h0055));
        drv1(1'b1, 16'h0066);
        if1.stall = 1'b1;
        if1.flush = 1'b1;
        #1;
        chk("sf_rdy", 128'(if1.in_ready), 128'(0));
        tick();
        chk("sf_ov", 128'(if1.out_valid), 128'(0));
        chk("sf_ctrl", 128'(if1.out_ctrl), 128'(0));
        chk("sf_data", 128'(if1.out_data), 128'(0));
        chk("sf_scnt", 128'(if1.stall_cnt), 128'(1));
        if1.stall = 1'b0;
        if1.flush = 1'b0;
        drv1(1'b0, '0);
        tick();
        chk("sf_still_empty", 128'(if1.out_valid), 128'(0));
        chk("sf_bcnt", 128'(if1.bubble_cnt), 128'(2));

        // Bubble counter saturation with 4-bit counters
        do_reset();
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 14 || k == 15 || k == 20)
                chk($sformatf("sat%0d", k), 128'(if1.bubble_cnt), 128'((k > 15) ? 15 : k));
        end

        chk("sb_empty0", 128'(q0.size()), 128'(0));
        chk("sb_empty1", 128'(q1.size()), 128'(0));
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Parametrised inter-stage pipeline register for the multi-cycle CPU datapath (D→E, E→M, M→W). It replaces per-stage hand-written registers.
- Carries an opaque data bus and a control bus with a valid/ready handshake, a stall input and a flush input.
- Optional 2-entry skid buffer breaks the combinational ready path. Saturating stall/bubble performance counters are included.
- A flushed or empty slot always presents all-zero control, so it behaves as a NOP.

Parameters:
- DATA_W, 96: width of datapath payload (operands, PC, immediates).
- CTRL_W, 16: width of control payload (RegWrite, MemWrite, ALU op, …). Zero means NOP.
- SKID, 1: 0 = single register with combinational ready; 1 = 2-entry skid buffer with registered in_ready.
- CNT_W, 16: width of the performance counters.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream stage presents an instruction.
- in_ready  out  1  this stage accepts on the current edge.
- in_data  in  DATA_W  upstream datapath payload.
- in_ctrl  in  CTRL_W  upstream control payload.
- stall  in  1  hazard unit holds the upstream stage; blocks input acceptance.
- flush  in  1  discard all held entries (branch/jump kill, load-use bubble).
- out_valid  out  1  downstream slot holds a live instruction.
- out_ready  in  1  downstream accepts on the current edge.
- out_data  out  DATA_W  payload to downstream.
- out_ctrl  out  CTRL_W  control to downstream.
- bubble_cnt  out  CNT_W  cycles with out_valid=0.
- stall_cnt  out  CNT_W  cycles with stall=1 and in_valid=1.

Behaviour:
- Reset (async, immediate):
  - All entries are invalid.
  - out_valid=0, out_data=0, out_ctrl=0.
  - Skid entry is cleared.
  - Both counters are 0.
  - in_ready=0 while reset is high (SKID=0 and SKID=1).
- Transfers:
  - Input transfer = in_valid & in_ready at a rising edge.
  - Output transfer = out_valid & out_ready at a rising edge.
- Zeroing invariant: whenever an entry becomes invalid (drained or flushed), its data and ctrl are loaded with 0. Therefore out_valid=0 implies out_data=0 and out_ctrl=0.
- Stall: gates input only (in_ready=0). The output side keeps draining, so a stalled upstream inserts bubbles downstream.
- Flush:
  - At the next edge all entries become invalid and zeroed; any input presented that cycle is dropped.
  - in_ready is forced to 0 during flush.
  - Flush has priority over stall and over both transfers.
  - Counters are not cleared by flush.
- SKID=0:
  - in_ready = ~stall & ~flush & (~out_valid | out_ready). This is combinational from out_ready.
  - Latency is 1 cycle.
  - Simultaneous input and output transfers reload the register in the same edge.
- SKID=1: states are EMPTY, ONE and FULL (main valid, skid valid).
  - in_ready = ~stall & ~flush & ~skid_valid. Only flush and stall reach in_ready combinationally; there is no out_ready→in_ready path.
  - EMPTY + input → ONE. The input goes to main; latency is 1 cycle.
  - ONE + input + output → ONE. Main is reloaded.
  - ONE + input, no output → FULL. The input goes to skid.
  - ONE + output, no input → EMPTY.
  - FULL + output → ONE. Skid moves to main and skid is zeroed. No input is possible in FULL.
  - Any state + flush → EMPTY.
  - Ordering is strictly FIFO; no entry is lost or duplicated.
- Counters:
  - bubble_cnt increments on every edge where out_valid=0 (sampled before the edge).
  - stall_cnt increments on every edge where stall & in_valid.
  - Both saturate at 2^CNT_W-1; there is no wrap.

Test Plan:
- Reset mid-stream: with SKID=1 in FULL holding ctrl 0x0011/0x0022, assert reset asynchronously between edges → out_valid=0, out_ctrl=0, in_ready=0, counters=0 immediately, with no clock edge needed.
- Stream: SKID=0, out_ready=1, feed ctrl 0x0001..0x0008 back-to-back → out_ctrl 0x0001..0x0008 one cycle later, with out_valid high 8 consecutive cycles.
- Backpressure: SKID=1, out_ready=0, feed A=0x00A1, B=0x00B2, C=0x00C3 → A and B accepted, in_ready drops after B and C is held upstream. Then out_ready=1 → outputs A, B, C in order.
- Stall + flush same cycle: in_valid=1, stall=1, flush=1 while ONE holds 0x0055 → next cycle out_valid=0, out_ctrl=0, out_data=0. stall_cnt has incremented by 1.
- Load-use bubble: stall=1 for 2 cycles with out_ready=1 and one entry held → the entry drains, then out_valid=0 and bubble_cnt counts 2; the stalled instruction issues after stall drops.
- Saturation: CNT_W=4, hold in_valid=0 for 20 cycles → bubble_cnt reaches 15 and stays at 15.
